demux_1n_stripe: RTL and testbench
==================================

DEMUX_1N_STRIPE -- requirements
Module: demux_1n_stripe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one symbol.
REQ-002 Parameter LANES, default 4, legal 2..8: number of output lanes.
REQ-003 clk4f  input  1: single byte-rate clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset, sampled on the rising edge of clk4f.
REQ-005 in0  input  WIDTH: incoming symbol stream.
REQ-006 valid_in0  input  1: in0 carries a symbol this cycle.
REQ-007 active_lanes  input  4: runtime link width, 1..LANES.
REQ-008 flush  input  1: emit the partially filled group.
REQ-009 out_data  output  LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 valid_out  output  LANES: per-lane valid strobe.
REQ-011 group_cnt  output  16: count of emitted groups.

Function
REQ-012 Symbols SHALL be striped round-robin: the first accepted symbol of a group goes to lane 0, the next to lane 1, and so on up to lane cur_lanes-1.
REQ-013 Lane pointer SHALL advance only on cycles with valid_in0=1; gaps SHALL hold the pointer and the gathered data, with no timeout.
REQ-014 cur_lanes SHALL be loaded from active_lanes on every cycle where pointer=0, and SHALL be held while pointer>0 (mid-group width changes ignored until the group completes).
REQ-015 active_lanes values of 0 or greater than LANES SHALL be treated as LANES.
REQ-016 On the edge that accepts the symbol for lane cur_lanes-1, out_data SHALL load all gathered lanes plus in0 (latency 1 cycle), and the pointer SHALL return to 0.
REQ-017 On that same edge, valid_out[k] SHALL be set to 1 for k<cur_lanes and to 0 otherwise.
REQ-018 Lanes at or above cur_lanes SHALL be driven 0 in out_data.
REQ-019 valid_out SHALL be 0 on every cycle following an edge with no emission; it SHALL be a one-cycle strobe unless back-to-back groups complete, e.g. cur_lanes=1 with continuous valid_in0.
REQ-020 out_data SHALL hold its last emitted value between emissions.
REQ-021 flush=1 with pointer>0 SHALL emit the filled lanes only: valid_out set for lanes < pointer (including the lane written this cycle if valid_in0=1), other lanes 0 in both data and valid; the pointer SHALL return to 0.
REQ-022 flush=1 with pointer=0 and valid_in0=1 SHALL emit a one-lane group (lane 0 only).
REQ-023 flush=1 with pointer=0 and valid_in0=0 SHALL have no effect.
REQ-024 flush coinciding with a natural group completion SHALL produce exactly one emission.
REQ-025 group_cnt SHALL increment by 1 per emission (full or flushed) and wrap from 0xFFFF to 0.
REQ-026 Gather registers SHALL clear to 0 after each emission so that stale data never appears on unfilled lanes.

Reset
REQ-027 With reset=0 at a rising edge: pointer=0, gather registers=0, out_data=0, valid_out=0, group_cnt=0, and cur_lanes=LANES, all at that edge.
REQ-028 Reset asserted mid-group SHALL discard the partial group with no emission.
REQ-029 The first symbol after reset deasserts SHALL map to lane 0.
REQ-030 valid_in0 and flush SHALL be ignored while reset=0.

Verification
REQ-031 LANES=4, active_lanes=4, in0=0xA0,0xA1,0xA2,0xA3 on consecutive valid cycles -> one cycle after the 0xA3 edge: out_data lanes 0..3=A0,A1,A2,A3; valid_out=4'b1111 for one cycle; group_cnt=1.
REQ-032 Same stream with valid_in0 low for 3 cycles between 0xA1 and 0xA2 -> identical output to REQ-031, emitted one cycle after 0xA3.
REQ-033 active_lanes=2 streaming 0x10..0x13 -> two emissions: (10,11) then (12,13), each with valid_out=4'b0011 and lanes 2..3 = 0; group_cnt=2.
REQ-034 Three symbols 0x55,0x66,0x77 followed by flush=1 with valid_in0=0 -> lanes=55,66,77,00; valid_out=4'b0111; next symbol maps to lane 0.
REQ-035 active_lanes changed from 4 to 1 after 2 symbols of a group -> that group completes as 4 lanes; subsequent symbols each emit with valid_out=4'b0001 on consecutive cycles.
REQ-036 reset=0 asserted after 2 of 4 symbols, then released and 4 new symbols sent -> no emission during reset; all outputs 0; the new group is emitted intact in lanes 0..3; group_cnt=1.

Source files
------------

// File: rtl/demux_1n_stripe_if.sv
// Bus bundle for the 1:N striping demux: symbol stream and link
// controls in, striped lane group plus strobes and group count out.
// Ports: in0, valid_in0, active_lanes, flush (to demux);
//        out_data, valid_out, group_cnt (from demux).
interface demux_1n_stripe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic [WIDTH-1:0]       in0;
    logic                   valid_in0;
    logic [3:0]             active_lanes;
    logic                   flush;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       valid_out;
    logic [15:0]            group_cnt;

    modport master (
        output in0, valid_in0, active_lanes, flush,
        input  out_data, valid_out, group_cnt
    );

    modport slave (
        input  in0, valid_in0, active_lanes, flush,
        output out_data, valid_out, group_cnt
    );
endinterface

// File: rtl/demux_1n_stripe.sv
// 1:N round-robin striping demux: gathers symbols into lanes
// 0..cur_lanes-1 and emits the group one cycle after its last symbol.
// Ports: clk4f (byte-rate clock), reset (sync, active low),
//        bus (slave side of demux_1n_stripe_if).
module demux_1n_stripe #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                clk4f,
    input  logic                reset,
    demux_1n_stripe_if.slave    bus
);
    localparam logic [3:0] LANES_W = 4'(LANES);

    logic [3:0]             ptr;
    logic [3:0]             cur_lanes;
    logic [LANES-1:0][WIDTH-1:0] gather;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       valid_out;
    logic [15:0]            group_cnt;

    logic [3:0]             eff_lanes;
    logic [3:0]             width;
    logic [3:0]             fill;
    logic                   last;
    logic                   emit;
    logic [LANES*WIDTH-1:0] emit_data;
    logic [LANES-1:0]       emit_valid;

    always_comb begin
        eff_lanes = bus.active_lanes;
        if (bus.active_lanes == 4'd0 || bus.active_lanes > LANES_W) begin
            eff_lanes = LANES_W;
        end
        // A new group samples the link width; mid-group it is frozen.
        width = (ptr == 4'd0) ? eff_lanes : cur_lanes;
        // Lanes holding data once this cycle's symbol is counted.
        fill  = ptr + {3'd0, bus.valid_in0};
        last  = bus.valid_in0 && (ptr == width - 4'd1);
        emit  = last || (bus.flush && fill != 4'd0);
    end

    always_comb begin
        emit_data  = '0;
        emit_valid = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(fill)) begin
                emit_valid[k] = 1'b1;
                if (k == int'(ptr)) begin
                    emit_data[k*WIDTH +: WIDTH] = bus.in0;
                end else begin
                    emit_data[k*WIDTH +: WIDTH] = gather[k];
                end
            end
        end
    end

    always_ff @(posedge clk4f) begin
        if (!reset) begin
            ptr       <= 4'd0;
            cur_lanes <= LANES_W;
            gather    <= '0;
            out_data  <= '0;
            valid_out <= '0;
            group_cnt <= 16'd0;
        end else begin
            cur_lanes <= width;
            if (emit) begin
                out_data  <= emit_data;
                valid_out <= emit_valid;
                ptr       <= 4'd0;
                // Cleared so unfilled lanes of the next group read 0.
                gather    <= '0;
                group_cnt <= group_cnt + 16'd1;
            end else begin
                valid_out <= '0;
                if (bus.valid_in0) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (k == int'(ptr)) begin
                            gather[k] <= bus.in0;
                        end
                    end
                    ptr <= ptr + 4'd1;
                end
            end
        end
    end

    assign bus.out_data  = out_data;
    assign bus.valid_out = valid_out;
    assign bus.group_cnt = group_cnt;
endmodule

// File: tb/tb_demux_1n_stripe.sv
// Self-checking bench for demux_1n_stripe: directed scenarios plus a
// randomized run compared against a queue-based group model.
module tb_demux_1n_stripe;
    localparam int W = 8;
    localparam int L = 4;

    logic clk4f = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    demux_1n_stripe_if #(.WIDTH(W), .LANES(L)) bus ();

    demux_1n_stripe #(.WIDTH(W), .LANES(L)) dut (
        .clk4f (clk4f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk4f = ~clk4f;

    // Reference model: a group is just a queue of symbols plus the
    // width seen when its first symbol arrived.
    logic [W-1:0]     grp[$];
    int               gw = L;
    logic [L*W-1:0]   m_data = '0;
    logic [L-1:0]     m_valid = '0;
    logic [15:0]      m_cnt = 16'd0;

    function automatic int eff(input logic [3:0] al);
        if (al == 0 || al > L) return L;
        return int'(al);
    endfunction

    task automatic model_step();
        if (!reset) begin
            grp.delete();
            gw = L;
            m_data = '0;
            m_valid = '0;
            m_cnt = 16'd0;
        end else begin
            if (grp.size() == 0) gw = eff(bus.active_lanes);
            if (bus.valid_in0) grp.push_back(bus.in0);
            if (grp.size() > 0 &&
                ((bus.valid_in0 && grp.size() == gw) || bus.flush)) begin
                m_data = '0;
                m_valid = '0;
                foreach (grp[i]) begin
                    m_data[i*W +: W] = grp[i];
                    m_valid[i] = 1'b1;
                end
                m_cnt = m_cnt + 16'd1;
                grp.delete();
            end else begin
                m_valid = '0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v,
                         input logic [W-1:0] d,
                         input logic [3:0] al, input logic f);
        reset = r;
        bus.valid_in0 = v;
        bus.in0 = d;
        bus.active_lanes = al;
        bus.flush = f;
        @(posedge clk4f);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 4'd4, 1'b0);
        cycle(1'b1, 1'b0, '0, 4'd4, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 8'hFF, 4'd4, 1'b1);
        cycle(1'b0, 1'b1, 8'hEE, 4'd4, 1'b1);
        tests++;
        if (bus.out_data !== '0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", bus.out_data);
        end
        tests++;
        if (bus.valid_out !== '0) begin
            fails++;
            $display("FAIL reset_valid got %b want 0", bus.valid_out);
        end
        tests++;
        if (bus.group_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt got %0d want 0", bus.group_cnt);
        end
        cycle(1'b1, 1'b0, '0, 4'd4, 1'b0);
    endtask

    task automatic test_full_group();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 8'hA0 + 8'(i), 4'd4, 1'b0);
            if (i < 3) begin
                tests++;
                if (bus.valid_out !== 4'b0000) begin
                    fails++;
                    $display("FAIL full_early_valid i=%0d got %b want 0000",
                             i, bus.valid_out);
                end
            end
        end
        tests++;
        if (bus.out_data !== 32'hA3A2A1A0 || bus.valid_out !== 4'b1111 ||
            bus.group_cnt !== 16'd1) begin
            fails++;
            $display("FAIL full_group got %h/%b/%0d want a3a2a1a0/1111/1",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
        cycle(1'b1, 1'b0, '0, 4'd4, 1'b0);
        tests++;
        if (bus.valid_out !== 4'b0000 || bus.out_data !== 32'hA3A2A1A0) begin
            fails++;
            $display("FAIL full_hold got %h/%b want a3a2a1a0/0000",
                     bus.out_data, bus.valid_out);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        cycle(1'b1, 1'b1, 8'hA0, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'hA1, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h5A, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'hA2, 4'd4, 1'b0);
        tests++;
        if (bus.valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL gaps_early got %b want 0000", bus.valid_out);
        end
        cycle(1'b1, 1'b1, 8'hA3, 4'd4, 1'b0);
        tests++;
        if (bus.out_data !== 32'hA3A2A1A0 || bus.valid_out !== 4'b1111 ||
            bus.group_cnt !== 16'd1) begin
            fails++;
            $display("FAIL gaps_group got %h/%b/%0d want a3a2a1a0/1111/1",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
    endtask

    task automatic test_two_lanes();
        do_reset();
        cycle(1'b1, 1'b1, 8'h10, 4'd2, 1'b0);
        cycle(1'b1, 1'b1, 8'h11, 4'd2, 1'b0);
        tests++;
        if (bus.out_data !== 32'h00001110 || bus.valid_out !== 4'b0011) begin
            fails++;
            $display("FAIL two_first got %h/%b want 00001110/0011",
                     bus.out_data, bus.valid_out);
        end
        cycle(1'b1, 1'b1, 8'h12, 4'd2, 1'b0);
        cycle(1'b1, 1'b1, 8'h13, 4'd2, 1'b0);
        tests++;
        if (bus.out_data !== 32'h00001312 || bus.valid_out !== 4'b0011 ||
            bus.group_cnt !== 16'd2) begin
            fails++;
            $display("FAIL two_second got %h/%b/%0d want 00001312/0011/2",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1'b1, 1'b1, 8'h55, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'h66, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 4'd4, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 4'd4, 1'b1);
        tests++;
        if (bus.out_data !== 32'h00776655 || bus.valid_out !== 4'b0111) begin
            fails++;
            $display("FAIL flush_partial got %h/%b want 00776655/0111",
                     bus.out_data, bus.valid_out);
        end
        cycle(1'b1, 1'b0, 8'h00, 4'd4, 1'b1);
        tests++;
        if (bus.valid_out !== 4'b0000 || bus.group_cnt !== 16'd1) begin
            fails++;
            $display("FAIL flush_idle got %b/%0d want 0000/1",
                     bus.valid_out, bus.group_cnt);
        end
        cycle(1'b1, 1'b1, 8'h88, 4'd4, 1'b1);
        tests++;
        if (bus.out_data !== 32'h00000088 || bus.valid_out !== 4'b0001 ||
            bus.group_cnt !== 16'd2) begin
            fails++;
            $display("FAIL flush_one got %h/%b/%0d want 00000088/0001/2",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
    endtask

    task automatic test_width_change();
        do_reset();
        cycle(1'b1, 1'b1, 8'hC0, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'hC1, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'hC2, 4'd1, 1'b0);
        cycle(1'b1, 1'b1, 8'hC3, 4'd1, 1'b0);
        tests++;
        if (bus.out_data !== 32'hC3C2C1C0 || bus.valid_out !== 4'b1111) begin
            fails++;
            $display("FAIL width_hold got %h/%b want c3c2c1c0/1111",
                     bus.out_data, bus.valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 8'hD0 + 8'(i), 4'd1, 1'b0);
            tests++;
            if (bus.out_data !== {24'd0, 8'hD0 + 8'(i)} ||
                bus.valid_out !== 4'b0001 ||
                bus.group_cnt !== 16'(2 + i)) begin
                fails++;
                $display("FAIL width_one i=%0d got %h/%b/%0d want %h/0001/%0d",
                         i, bus.out_data, bus.valid_out, bus.group_cnt,
                         8'hD0 + 8'(i), 2 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b1, 8'h31, 4'd4, 1'b0);
        cycle(1'b1, 1'b1, 8'h32, 4'd4, 1'b0);
        cycle(1'b0, 1'b1, 8'h33, 4'd4, 1'b1);
        tests++;
        if (bus.out_data !== '0 || bus.valid_out !== '0 ||
            bus.group_cnt !== 16'd0) begin
            fails++;
            $display("FAIL midrst_outs got %h/%b/%0d want 0/0/0",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'h40 + 8'(i), 4'd4, 1'b0);
        tests++;
        if (bus.out_data !== 32'h43424140 || bus.valid_out !== 4'b1111 ||
            bus.group_cnt !== 16'd1) begin
            fails++;
            $display("FAIL midrst_group got %h/%b/%0d want 43424140/1111/1",
                     bus.out_data, bus.valid_out, bus.group_cnt);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  W'($urandom),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0));
            tests++;
            if (bus.out_data !== m_data || bus.valid_out !== m_valid ||
                bus.group_cnt !== m_cnt) begin
                fails++;
                if (errs < 10)
                    $display("FAIL random n=%0d got %h/%b/%0d want %h/%b/%0d",
                             n, bus.out_data, bus.valid_out, bus.group_cnt,
                             m_data, m_valid, m_cnt);
                errs++;
            end
        end
    endtask

    initial begin
        bus.in0 = '0;
        bus.valid_in0 = 1'b0;
        bus.active_lanes = 4'd4;
        bus.flush = 1'b0;
        test_reset();
        test_full_group();
        test_gaps();
        test_two_lanes();
        test_flush();
        test_width_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
